// File: rtl/regmask_encoder.sv
// -----------------------------------------------------------------------------
// regmask_encoder
//   Sequential 32-to-5 mask encoder for the register-file write path. A 32-bit
//   multi-hot mask is captured and then drained one register index per
//   handshake, lowest index first, so one 5-bit write-select port can service
//   a multi-register update.
//
// Ports
//   clock          in   1   rising-edge clock
//   reset_n        in   1   asynchronous active-low reset
//   mask_in        in  32   register mask, bit i = register i pending
//   load           in   1   capture mask_in (only while not busy)
//   flush          in   1   synchronous abort of all pending work
//   out_ready      in   1   consumer takes out_index this cycle
//   out_valid      out  1   out_index names a pending register
//   out_index      out  5   lowest pending register index (0 when idle)
//   busy           out  1   pending mask is non-empty
//   done           out  1   one-cycle pulse after a job completes
//   pending_count  out  6   number of registers still pending (0..32)
// -----------------------------------------------------------------------------
module regmask_encoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] mask_in,
  input  logic        load,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_index,
  output logic        busy,
  output logic        done,
  output logic [5:0]  pending_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pending;
  logic        r_out_valid;
  logic [4:0]  r_out_index;
  logic        r_done;
  logic [5:0]  r_pending_count;

  logic [31:0] w_next_pending;
  logic        w_handshake;

  // Index of the lowest set bit; 0 for an empty vector so an idle
  // out_index reads 0.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

  // Number of set bits in a 32-bit vector (0..32).
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

  // Pending mask after retiring the currently presented index.
  always_comb begin
    w_next_pending = r_pending & ~(32'd1 << r_out_index);
  end

  assign w_handshake = r_out_valid & out_ready;

  // Job state machine: capture, drain one index per handshake, pulse done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_pending       <= 32'd0;
      r_out_valid     <= 1'b0;
      r_out_index     <= 5'd0;
      r_done          <= 1'b0;
      r_pending_count <= 6'd0;
    end else if (flush) begin
      // Abort silently: no done pulse, any same-cycle load is dropped.
      r_state         <= ST_IDLE;
      r_pending       <= 32'd0;
      r_out_valid     <= 1'b0;
      r_out_index     <= 5'd0;
      r_done          <= 1'b0;
      r_pending_count <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_pending       <= mask_in;
            r_out_index     <= lowest_set(mask_in);
            r_out_valid     <= |mask_in;
            r_pending_count <= popcount(mask_in);
            // An empty job completes immediately.
            r_done          <= ~(|mask_in);
            r_state         <= (|mask_in) ? ST_SCAN : ST_IDLE;
          end else begin
            r_done <= 1'b0;
          end
        end
        ST_SCAN: begin
          // load is ignored here; outputs only move on a handshake.
          if (w_handshake) begin
            r_pending       <= w_next_pending;
            r_out_index     <= lowest_set(w_next_pending);
            r_out_valid     <= |w_next_pending;
            r_pending_count <= r_pending_count - 6'd1;
            r_done          <= ~(|w_next_pending);
            r_state         <= (|w_next_pending) ? ST_SCAN : ST_IDLE;
          end else begin
            r_done <= 1'b0;
          end
        end
        default: begin
          r_state         <= ST_IDLE;
          r_pending       <= 32'd0;
          r_out_valid     <= 1'b0;
          r_out_index     <= 5'd0;
          r_done          <= 1'b0;
          r_pending_count <= 6'd0;
        end
      endcase
    end
  end

  assign out_valid     = r_out_valid;
  assign out_index     = r_out_index;
  assign done          = r_done;
  assign pending_count = r_pending_count;
  assign busy          = |r_pending;

endmodule

// File: tb/tb_regmask_encoder.sv
module tb_regmask_encoder;

  logic        clock;
  logic        reset_n;
  logic [31:0] mask_in;
  logic        load;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_index;
  logic        busy;
  logic        done;
  logic [5:0]  pending_count;

  int n_cmp;
  int n_bad;

  // Reference model: list of register indices still owed, in issue order,
  // plus the expected done pulse.
  int m_q[$];
  bit m_done;

  regmask_encoder dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .mask_in       (mask_in),
    .load          (load),
    .flush         (flush),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_index     (out_index),
    .busy          (busy),
    .done          (done),
    .pending_count (pending_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int exp_idx;
    exp_idx = (m_q.size() > 0) ? m_q[0] : 0;
    check_eq({tag, ".valid"}, {31'd0, out_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
    check_eq({tag, ".index"}, {27'd0, out_index}, exp_idx);
    check_eq({tag, ".busy"},  {31'd0, busy},      (m_q.size() > 0) ? 32'd1 : 32'd0);
    check_eq({tag, ".done"},  {31'd0, done},      {31'd0, m_done});
    check_eq({tag, ".count"}, {26'd0, pending_count}, m_q.size());
  endtask

  // One clock cycle: drive at negedge, advance the model at posedge, check.
  task automatic step(input string tag, input bit ld, input logic [31:0] m,
                      input bit fl, input bit rd);
    bit new_done;
    @(negedge clock);
    load      = ld;
    mask_in   = m;
    flush     = fl;
    out_ready = rd;
    @(posedge clock);
    new_done = 1'b0;
    if (fl) begin
      m_q.delete();
    end else if (m_q.size() == 0) begin
      if (ld) begin
        for (int i = 0; i < 32; i++) begin
          if (m[i]) m_q.push_back(i);
        end
        if (m == 32'd0) new_done = 1'b1;
      end
    end else if (rd) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) new_done = 1'b1;
    end
    m_done = new_done;
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_steps(input string tag, input int n, input bit rd);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 32'd0, 1'b0, rd);
  endtask

  initial begin
    logic [31:0] rmask;
    int          sel;
    n_cmp     = 0;
    n_bad     = 0;
    m_done    = 1'b0;
    reset_n   = 1'b0;
    load      = 1'b0;
    mask_in   = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    idle_steps("post_reset", 2, 1'b1);

    // Basic ascending sequence including bit 31.
    step("basic_load", 1'b1, 32'h8000_0011, 1'b0, 1'b1);
    idle_steps("basic", 4, 1'b1);

    // Back-pressure: presented index must hold.
    step("bp_load", 1'b1, 32'h0000_000A, 1'b0, 1'b0);
    idle_steps("bp_hold", 5, 1'b0);
    idle_steps("bp_drain", 3, 1'b1);

    // Zero mask, then load while busy ignored.
    step("zero_load", 1'b1, 32'd0, 1'b0, 1'b1);
    idle_steps("zero_after", 2, 1'b1);
    step("job3_load", 1'b1, 32'h0000_0003, 1'b0, 1'b0);
    step("busy_load", 1'b1, 32'h0000_00F0, 1'b0, 1'b0);
    step("busy_load2", 1'b1, 32'h0000_00F0, 1'b0, 1'b1);
    idle_steps("job3_drain", 3, 1'b1);

    // Flush with simultaneous load.
    step("fl_load", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle_steps("fl_hs", 3, 1'b1);
    step("flush", 1'b1, 32'h0000_0005, 1'b1, 1'b1);
    idle_steps("fl_after", 2, 1'b1);

    // Full mask, then back-to-back load on the done cycle.
    step("full_load", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle_steps("full_drain", 32, 1'b1);
    step("b2b_load", 1'b1, 32'h0000_0001, 1'b0, 1'b1);
    idle_steps("b2b_drain", 2, 1'b1);

    // Asynchronous reset in the middle of a job.
    step("rst_load", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle_steps("rst_hs", 2, 1'b1);
    #2;
    reset_n = 1'b0;
    m_q.delete();
    m_done = 1'b0;
    #1;
    check_outputs("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    idle_steps("rst_after", 2, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rmask = 32'd0;
        1:       rmask = $urandom;
        2:       rmask = $urandom & $urandom & $urandom;
        default: rmask = 32'd1 << $urandom_range(0, 31);
      endcase
      step("rand", ($urandom % 3) == 0, rmask, ($urandom % 40) == 0, ($urandom % 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regmask_encoder.md
# regmask_encoder

Sequential 32-to-5 mask encoder for the register file write path. Accepts a 32-bit multi-hot register mask and emits, one per handshake, the 5-bit index of every set bit in ascending order, so a single 5-bit write-select port (fed to the 5-to-32 write-enable decoder) can service a multi-register update. Sits between the block that produces register-update masks and the regfile write-select/enable logic.

## Interface
Parameters: none. Widths are fixed at 32 registers and a 5-bit index.
- clock  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- mask_in  input  32  register mask; bit i set = register i pending
- load  input  1  capture mask_in; honoured only when busy=0
- flush  input  1  synchronous abort; clears all pending work
- out_ready  input  1  consumer accepts out_index this cycle
- out_valid  output  1  out_index holds a pending register
- out_index  output  5  index of lowest pending register
- busy  output  1  job in progress (pending mask non-empty)
- done  output  1  one-cycle pulse when a job completes
- pending_count  output  6  number of set bits still pending (0..32)

## Operation
- State: pending[31:0], plus registered out_valid, out_index, done and pending_count. busy = (pending != 0).
- Two states: IDLE (pending=0) and SCAN (pending≠0).
- IDLE + load:
  - pending <= mask_in.
  - out_index <= lowest set bit of mask_in.
  - out_valid <= |mask_in.
  - pending_count <= popcount(mask_in).
- IDLE + load with mask_in=0: no outputs issued; done pulses next cycle; remains IDLE.
- SCAN + handshake (out_valid && out_ready):
  - next = pending & ~(1 << out_index).
  - pending <= next.
  - out_index <= lowest set bit of next.
  - out_valid <= |next.
  - pending_count decrements by 1.
- The last handshake (next=0) pulses done on the following cycle, with out_valid=0, and returns to IDLE.
- load while busy=1 is ignored; the in-flight job is not modified.
- flush has priority over load and handshake:
  - pending, out_valid, pending_count <= 0; out_index <= 0.
  - done is not pulsed.
  - A load in the same cycle as flush is dropped.
- out_index when out_valid=0 is 0.
- Priority order is strictly ascending, bit 0 first. Bit 31 is a legal index; there is no wrap.
- Handshake rule: once out_valid=1, out_index and out_valid stay stable until out_ready=1, regardless of load.
- out_ready while out_valid=0 has no effect.

## Timing
- Reset (reset_n=0, asynchronous): pending=0, out_valid=0, out_index=0, done=0, pending_count=0, busy=0. Outputs take these values immediately on assertion. Deassertion mid-job loses the job.
- Latency: load at edge N → out_valid/out_index valid after edge N (visible cycle N+1).
- Throughput: one index per cycle while out_ready is held high. A mask with k set bits completes in k handshake cycles.
- done asserts the cycle after the final handshake, for exactly one cycle. busy deasserts in that same cycle.
- A new load is accepted in the same cycle done is high, since busy=0 then. The next job's first out_valid follows one cycle later.
- Zero-mask load: done one cycle after load; out_valid never asserts.
- All outputs are registered or decoded from registers only (busy). There is no combinational path from any input to any output.

## Test plan
- Reset: assert reset_n=0 mid-job with mask 0xFFFF_FFFF → all outputs 0 immediately. After release, busy=0 and out_valid=0.
- Basic sequence: load 0x8000_0011 with out_ready=1 → out_index 0, 4, 31 on consecutive cycles. pending_count reads 3, 2, 1. done pulses on the 4th cycle after load; busy=0 then.
- Back-pressure: load 0x0000_000A with out_ready=0 for 5 cycles → out_index holds 1 and out_valid holds 1. Then out_ready=1 → 3, then done.
- Zero mask and ignored load: load 0 → done pulse next cycle, no out_valid. During a job on 0x3, load 0xF0 → ignored; emits only 0 and 1.
- Flush: load 0xFFFF_FFFF, take 3 handshakes, assert flush together with load=1 → next cycle out_valid=0, pending_count=0, no done pulse, load dropped.
- Full mask plus back-to-back jobs: load 0xFFFF_FFFF with out_ready=1 → indices 0..31 in 32 cycles, pending_count starts at 32. Load 0x1 on the done cycle → index 0 emitted the next cycle.
